// File: rtl/mont_pkg.sv
// Shared Montgomery-multiplier definitions: FSM encoding, default geometry, counter sizing.
// Also used by the modular exponentiation controller.
package mont_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOP   = 2'd1,
    ST_REDUCE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int unsigned MONT_WIDTH = 512;
  localparam int unsigned MONT_K     = 1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mont_step.sv
// One combinational radix-2 Montgomery step: C' = (C + a*B + q*M) / 2, q chosen so the sum is even.
// Zero latency; no flow control.
module mont_step #(
  parameter int unsigned WIDTH = 512
) (
  input  logic [WIDTH+1:0] c_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic             a_bit_i,
  output logic [WIDTH+1:0] c_o
);

  logic             q;
  logic [WIDTH+2:0] sum;
  logic             unused_lsb;

  assign q   = c_i[0] ^ (a_bit_i & b_i[0]);
  assign sum = {1'b0, c_i}
             + {3'b000, b_i & {WIDTH{a_bit_i}}}
             + {3'b000, m_i & {WIDTH{q}}};

  // The LSB of sum is zero by construction of q, so it is simply dropped.
  assign c_o        = sum[WIDTH+2:1];
  assign unused_lsb = sum[0];

endmodule

// File: rtl/montgomery_mult_param.sv
// Radix-2^K interleaved Montgomery multiplier: result = a*b*2^-WIDTH mod m.
// Latency WIDTH/K+2 cycles from accepted start to done; start is ignored while busy.
module montgomery_mult_param
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = MONT_WIDTH,
  parameter int unsigned K     = MONT_K
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             error
);

  localparam int unsigned L  = WIDTH / K;
  localparam int unsigned CW = (clog2(L) < 1) ? 1 : clog2(L);
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH+1:0] c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             error_q, error_d;

  logic [WIDTH+1:0] chain [K+1];
  logic             c_ge_m;
  logic [WIDTH-1:0] c_minus_m;

  assign chain[0] = c_q;

  for (genvar i = 0; i < K; i++) begin : g_step
    mont_step #(.WIDTH(WIDTH)) u_step (
      .c_i    (chain[i]),
      .b_i    (b_q),
      .m_i    (m_q),
      .a_bit_i(a_q[i]),
      .c_o    (chain[i+1])
    );
  end

  // C < 2M, so one conditional subtraction yields the canonical residue;
  // the low WIDTH bits of C - M are exact whenever C >= M.
  assign c_ge_m    = (c_q >= {2'b00, m_q});
  assign c_minus_m = c_q[WIDTH-1:0] - m_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d      = in_a;
          b_d      = in_b;
          m_d      = in_m;
          c_d      = '0;
          cnt_d    = '0;
          result_d = '0;
          error_d  = ~in_m[0];
          state_d  = in_m[0] ? ST_LOOP : ST_DONE;
        end
      end
      ST_LOOP: begin
        c_d   = chain[K];
        a_d   = a_q >> K;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = ST_REDUCE;
      end
      ST_REDUCE: begin
        result_d = c_ge_m ? c_minus_m : c_q[WIDTH-1:0];
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      c_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q != ST_IDLE);
  assign error  = error_q;

endmodule

// File: tb/tb_montgomery_mult_param.sv
// Bench for montgomery_mult_param: three 8-bit instances (K=1,2,4) sharing stimulus, plus a 512-bit K=1 instance.
module tb_montgomery_mult_param;

  logic clk = 1'b0;
  logic resetn;
  logic start8, start512;
  logic [7:0]   in_a8, in_b8, in_m8;
  logic [511:0] in_a512, in_b512, in_m512;

  logic [7:0]   res1, res2, res4;
  logic         done1, done2, done4, busy1, busy2, busy4, err1, err2, err4;
  logic [511:0] res512;
  logic         done512, busy512, err512;

  int n_checks = 0;
  int n_fail   = 0;
  logic [512:0] sb_q[$];

  always #5 clk = ~clk;

  montgomery_mult_param #(.WIDTH(8), .K(1)) u8k1 (
    .clk(clk), .resetn(resetn), .start(start8), .in_a(in_a8), .in_b(in_b8), .in_m(in_m8),
    .result(res1), .done(done1), .busy(busy1), .error(err1));
  montgomery_mult_param #(.WIDTH(8), .K(2)) u8k2 (
    .clk(clk), .resetn(resetn), .start(start8), .in_a(in_a8), .in_b(in_b8), .in_m(in_m8),
    .result(res2), .done(done2), .busy(busy2), .error(err2));
  montgomery_mult_param #(.WIDTH(8), .K(4)) u8k4 (
    .clk(clk), .resetn(resetn), .start(start8), .in_a(in_a8), .in_b(in_b8), .in_m(in_m8),
    .result(res4), .done(done4), .busy(busy4), .error(err4));
  montgomery_mult_param #(.WIDTH(512), .K(1)) u512 (
    .clk(clk), .resetn(resetn), .start(start512), .in_a(in_a512), .in_b(in_b512), .in_m(in_m512),
    .result(res512), .done(done512), .busy(busy512), .error(err512));

  // a*b*2^-w mod m via reduction followed by w modular halvings.
  function automatic logic [511:0] ref_mont(input logic [511:0] a, b, m, input int w);
    logic [1025:0] x, mm;
    mm = {514'b0, m};
    x  = ({514'b0, a} * {514'b0, b}) % mm;
    for (int i = 0; i < w; i++) x = x[0] ? ((x + mm) >> 1) : (x >> 1);
    return x[511:0];
  endfunction

  task automatic test_reset;
    resetn = 1'b0; start8 = 1'b0; start512 = 1'b0;
    in_a8 = '0; in_b8 = '0; in_m8 = '0; in_a512 = '0; in_b512 = '0; in_m512 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if ({done1, busy1, err1, res1} !== 11'd0) begin n_fail++; $display("FAIL reset_k1: got %0h want 0", {done1, busy1, err1, res1}); end
    n_checks++; if ({done2, busy2, err2, res2} !== 11'd0) begin n_fail++; $display("FAIL reset_k2: got %0h want 0", {done2, busy2, err2, res2}); end
    n_checks++; if ({done4, busy4, err4, res4} !== 11'd0) begin n_fail++; $display("FAIL reset_k4: got %0h want 0", {done4, busy4, err4, res4}); end
    n_checks++; if ({done512, busy512, err512, res512} !== 515'd0) begin n_fail++; $display("FAIL reset_512: outputs not zero"); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // One operation on all three 8-bit instances; checks latency, result and error of each.
  task automatic op8(input logic [7:0] a, b, m);
    logic [511:0] r;
    logic [512:0] e;
    int t1, t2, t4, l1, l2, l4;
    logic [7:0] r1, r2, r4;
    logic e1, e2, e4;
    r = ref_mont({504'b0, a}, {504'b0, b}, {504'b0, m}, 8);
    sb_q.push_back(m[0] ? {1'b0, r} : {1'b1, 512'b0});
    in_a8 = a; in_b8 = b; in_m8 = m; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    t1 = -1; t2 = -1; t4 = -1; r1 = '0; r2 = '0; r4 = '0; e1 = 1'b0; e2 = 1'b0; e4 = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done1 && t1 < 0) begin t1 = n; r1 = res1; e1 = err1; end
      if (done2 && t2 < 0) begin t2 = n; r2 = res2; e2 = err2; end
      if (done4 && t4 < 0) begin t4 = n; r4 = res4; e4 = err4; end
      if (t1 > 0 && t2 > 0 && t4 > 0) break;
    end
    @(negedge clk);
    e  = sb_q.pop_front();
    l1 = m[0] ? 10 : 1; l2 = m[0] ? 6 : 1; l4 = m[0] ? 4 : 1;
    n_checks++; if (t1 !== l1) begin n_fail++; $display("FAIL lat_k1 m=%0d: got %0d want %0d", m, t1, l1); end
    n_checks++; if (t2 !== l2) begin n_fail++; $display("FAIL lat_k2 m=%0d: got %0d want %0d", m, t2, l2); end
    n_checks++; if (t4 !== l4) begin n_fail++; $display("FAIL lat_k4 m=%0d: got %0d want %0d", m, t4, l4); end
    n_checks++; if ({e1, r1} !== {e[512], e[7:0]}) begin n_fail++; $display("FAIL res_k1 a=%0d b=%0d m=%0d: got err=%0b res=%0d want err=%0b res=%0d", a, b, m, e1, r1, e[512], e[7:0]); end
    n_checks++; if ({e2, r2} !== {e[512], e[7:0]}) begin n_fail++; $display("FAIL res_k2 a=%0d b=%0d m=%0d: got err=%0b res=%0d want err=%0b res=%0d", a, b, m, e2, r2, e[512], e[7:0]); end
    n_checks++; if ({e4, r4} !== {e[512], e[7:0]}) begin n_fail++; $display("FAIL res_k4 a=%0d b=%0d m=%0d: got err=%0b res=%0d want err=%0b res=%0d", a, b, m, e4, r4, e[512], e[7:0]); end
  endtask

  task automatic test_busy_window;
    logic [512:0] e;
    sb_q.push_back({1'b0, ref_mont(512'd5, 512'd7, 512'd13, 8)});
    in_a8 = 8'd5; in_b8 = 8'd7; in_m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      n_checks++; if (busy1 !== (n <= 10)) begin n_fail++; $display("FAIL busy_cyc%0d: got %0b want %0b", n, busy1, (n <= 10)); end
      n_checks++; if (done1 !== (n == 10)) begin n_fail++; $display("FAIL done_cyc%0d: got %0b want %0b", n, done1, (n == 10)); end
      if (n == 10) begin
        e = sb_q.pop_front();
        n_checks++; if ({err1, res1} !== {e[512], e[7:0]}) begin n_fail++; $display("FAIL basic_res: got %0d want %0d", res1, e[7:0]); end
      end
    end
  endtask

  task automatic test_k_variants;
    op8(8'd5, 8'd7, 8'd13);
    op8(8'd12, 8'd12, 8'd13);
    op8(8'd0, 8'd9, 8'd13);
    op8(8'd250, 8'd200, 8'd251);
  endtask

  task automatic test_even_modulus;
    op8(8'd9, 8'd4, 8'd12);
    n_checks++; if ({err1, err2, err4} !== 3'b111) begin n_fail++; $display("FAIL err_held: got %0b want 111", {err1, err2, err4}); end
    op8(8'd5, 8'd7, 8'd13);
  endtask

  task automatic test_random;
    logic [7:0] a, b, m, mm;
    for (int i = 0; i < 2000; i++) begin
      mm = 8'($urandom_range(1, 127));
      m  = {mm[6:0], 1'b1};
      a  = 8'($urandom_range(0, int'(m) - 1));
      b  = 8'($urandom_range(0, int'(m) - 1));
      op8(a, b, m);
    end
  endtask

  task automatic test_start_while_busy;
    logic [512:0] e;
    logic [7:0] r1;
    int cnt;
    sb_q.push_back({1'b0, ref_mont(512'd5, 512'd7, 512'd13, 8)});
    in_a8 = 8'd5; in_b8 = 8'd7; in_m8 = 8'd13; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    in_a8 = 8'd12; in_b8 = 8'd12; in_m8 = 8'd11;
    cnt = 0; r1 = '0;
    for (int n = 1; n <= 25; n++) begin
      @(negedge clk);
      start8 = (n == 3 || n == 7);
      if (done1) begin cnt++; r1 = res1; end
    end
    start8 = 1'b0;
    e = sb_q.pop_front();
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL swb_done_count: got %0d want 1", cnt); end
    n_checks++; if (r1 !== e[7:0]) begin n_fail++; $display("FAIL swb_result: got %0d want %0d", r1, e[7:0]); end
    n_checks++; if (res1 !== e[7:0]) begin n_fail++; $display("FAIL swb_held: got %0d want %0d", res1, e[7:0]); end
  endtask

  task automatic test_back_to_back;
    logic [512:0] e;
    int times [3];
    int k;
    for (int i = 0; i < 3; i++) sb_q.push_back({1'b0, ref_mont(512'd5, 512'd7, 512'd13, 8)});
    in_a8 = 8'd5; in_b8 = 8'd7; in_m8 = 8'd13; start8 = 1'b1;
    k = 0; times[0] = -1; times[1] = -1; times[2] = -1;
    @(posedge clk);
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      if (done1) begin
        if (k < 3) begin
          times[k] = n;
          e = sb_q.pop_front();
          n_checks++; if (res1 !== e[7:0]) begin n_fail++; $display("FAIL b2b_res%0d: got %0d want %0d", k, res1, e[7:0]); end
        end
        k++;
      end
    end
    start8 = 1'b0;
    while (sb_q.size() > 0) void'(sb_q.pop_front());
    repeat (15) @(negedge clk);
    n_checks++; if (k !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", k); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (times[i] !== 10 + 11 * i) begin n_fail++; $display("FAIL b2b_time%0d: got %0d want %0d", i, times[i], 10 + 11 * i); end
    end
  endtask

  task automatic test_reset_mid_op;
    logic [511:0] a, b, m, r;
    logic [512:0] e;
    logic er;
    int t;
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < 16; i++) begin
        a[i*32 +: 32] = $urandom();
        b[i*32 +: 32] = $urandom();
        m[i*32 +: 32] = $urandom();
      end
      a[511] = 1'b0; b[511] = 1'b0; m[511] = 1'b1; m[0] = 1'b1;
      if (run != 1) sb_q.push_back({1'b0, ref_mont(a, b, m, 512)});
      in_a512 = a; in_b512 = b; in_m512 = m; start512 = 1'b1;
      @(posedge clk); #1 start512 = 1'b0;
      t = -1; r = '0; er = 1'b0;
      for (int n = 1; n <= 600; n++) begin
        @(negedge clk);
        if (run == 1 && n == 5) resetn = 1'b0;
        if (run == 1 && n == 6) begin
          n_checks++; if ({done512, busy512, err512, res512} !== 515'd0) begin n_fail++; $display("FAIL rst512_outputs: done=%0b busy=%0b err=%0b res=%0h want all 0", done512, busy512, err512, res512); end
          resetn = 1'b1;
        end
        if (done512 && t < 0) begin t = n; r = res512; er = err512; end
      end
      if (run == 1) begin
        n_checks++; if (t !== -1) begin n_fail++; $display("FAIL rst512_no_done: got done at %0d want none", t); end
      end else begin
        e = sb_q.pop_front();
        n_checks++; if (t !== 514) begin n_fail++; $display("FAIL lat512_run%0d: got %0d want 514", run, t); end
        n_checks++; if ({er, r} !== e) begin n_fail++; $display("FAIL res512_run%0d: got %0h want %0h", run, r, e[511:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_busy_window();
    test_k_variants();
    test_even_modulus();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
